// File: rtl/fdc1771_seek_ctrl.sv
// Head-positioning sequencer for a 1771-style floppy controller.
// Runs seek and restore commands by issuing timed step pulses, then
// waits for the head to settle before reporting completion.
// Step periods are parameters so the controller can be retargeted.
module fdc1771_seek_ctrl #(
  parameter logic [16:0] PULSE_TICKS   = 17'd12,
  parameter logic [16:0] SETTLE_TICKS  = 17'd45000,
  parameter logic [7:0]  RESTORE_LIMIT = 8'd255,
  parameter logic [16:0] RATE0_TICKS   = 17'd18000,
  parameter logic [16:0] RATE1_TICKS   = 17'd36000,
  parameter logic [16:0] RATE2_TICKS   = 17'd60000,
  parameter logic [16:0] RATE3_TICKS   = 17'd120000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_3mhz_en,
  input  logic       cmd_strobe,
  input  logic       cmd_restore,
  input  logic [1:0] cmd_rate,
  input  logic [5:0] target_track,
  input  logic       drive_ready,
  input  logic [5:0] drive_track,
  output logic       step,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] track_reg
);

  typedef enum logic [2:0] {IDLE, CHECK, PULSE, RATE, SETTLE, DONE} state_t;

  state_t      state_reg;
  logic [16:0] timer_reg;
  logic [7:0]  step_cnt_reg;
  logic        stepped_reg;
  logic        restore_reg;
  logic [1:0]  rate_reg;
  logic [5:0]  target_reg;

  logic [16:0] period_ticks;
  logic [16:0] rate_last;

  // Step period for the latched rate; the rate wait excludes the pulse high time
  always_comb begin
    period_ticks = RATE0_TICKS;
    case (rate_reg)
      2'd0: period_ticks = RATE0_TICKS;
      2'd1: period_ticks = RATE1_TICKS;
      2'd2: period_ticks = RATE2_TICKS;
      2'd3: period_ticks = RATE3_TICKS;
      default: period_ticks = RATE0_TICKS;
    endcase
    rate_last = period_ticks - PULSE_TICKS - 17'd1;
  end

  // Command sequencer; all outputs are registered, done is set on entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      timer_reg    <= 17'd0;
      step_cnt_reg <= 8'd0;
      stepped_reg  <= 1'b0;
      restore_reg  <= 1'b0;
      rate_reg     <= 2'd0;
      target_reg   <= 6'd0;
      step         <= 1'b0;
      dir          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      track_reg    <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_strobe) begin
            restore_reg  <= cmd_restore;
            rate_reg     <= cmd_rate;
            target_reg   <= target_track;
            error        <= 1'b0;
            busy         <= 1'b1;
            stepped_reg  <= 1'b0;
            step_cnt_reg <= 8'd0;
            timer_reg    <= 17'd0;
            state_reg    <= CHECK;
          end
        end
        CHECK: begin
          timer_reg <= 17'd0;
          if (!drive_ready) begin
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end else if (restore_reg) begin
            if (drive_track == 6'd0) begin
              track_reg <= 6'd0;
              if (stepped_reg) begin
                state_reg <= SETTLE;
              end else begin
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= DONE;
              end
            end else if (step_cnt_reg == RESTORE_LIMIT) begin
              error     <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              dir       <= 1'b0;
              state_reg <= PULSE;
            end
          end else begin
            // Seek relies only on the internal track register
            if (track_reg == target_reg) begin
              if (stepped_reg) begin
                state_reg <= SETTLE;
              end else begin
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= DONE;
              end
            end else begin
              dir       <= (target_reg > track_reg);
              state_reg <= PULSE;
            end
          end
        end
        PULSE: begin
          // First cycle only raises step, so dir has been stable for a full clk
          if (!step) begin
            step <= 1'b1;
          end else if (clk_3mhz_en) begin
            if (timer_reg == PULSE_TICKS - 17'd1) begin
              step        <= 1'b0;
              timer_reg   <= 17'd0;
              stepped_reg <= 1'b1;
              state_reg   <= RATE;
              if (restore_reg) begin
                step_cnt_reg <= step_cnt_reg + 8'd1;
              end else if (dir) begin
                track_reg <= track_reg + 6'd1;
              end else begin
                track_reg <= track_reg - 6'd1;
              end
            end else begin
              timer_reg <= timer_reg + 17'd1;
            end
          end
        end
        RATE: begin
          if (clk_3mhz_en) begin
            if (timer_reg == rate_last) begin
              timer_reg <= 17'd0;
              state_reg <= CHECK;
            end else begin
              timer_reg <= timer_reg + 17'd1;
            end
          end
        end
        SETTLE: begin
          if (clk_3mhz_en) begin
            if (timer_reg == SETTLE_TICKS - 17'd1) begin
              timer_reg <= 17'd0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              timer_reg <= timer_reg + 17'd1;
            end
          end
        end
        DONE: begin
          // done is high for this one cycle; a strobe here is dropped
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc1771_seek_ctrl.sv
// Scoreboard bench for fdc1771_seek_ctrl with shortened timing parameters.
module tb_fdc1771_seek_ctrl;

  localparam logic [16:0] P_T = 17'd3;
  localparam logic [16:0] S_T = 17'd40;
  localparam logic [7:0]  LIM = 8'd12;
  localparam int R0 = 20;
  localparam int R1 = 30;
  localparam int R2 = 45;
  localparam int R3 = 70;
  localparam int S  = 40;
  localparam int BIG = 100000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_3mhz_en;
  logic       cmd_strobe;
  logic       cmd_restore;
  logic [1:0] cmd_rate;
  logic [5:0] target_track;
  logic       drive_ready;
  logic [5:0] drive_track;
  logic       step, dir, busy, done, error;
  logic [5:0] track_reg;

  logic [5:0] drive_pos;
  logic       drive_moves = 1'b0;
  logic       drive_hold9 = 1'b0;
  int         en_div = 0;

  assign drive_track = drive_hold9 ? 6'd9 : drive_pos;

  fdc1771_seek_ctrl #(
    .PULSE_TICKS(P_T), .SETTLE_TICKS(S_T), .RESTORE_LIMIT(LIM),
    .RATE0_TICKS(17'd20), .RATE1_TICKS(17'd30), .RATE2_TICKS(17'd45), .RATE3_TICKS(17'd70)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_3mhz_en(clk_3mhz_en),
    .cmd_strobe(cmd_strobe), .cmd_restore(cmd_restore), .cmd_rate(cmd_rate),
    .target_track(target_track), .drive_ready(drive_ready), .drive_track(drive_track),
    .step(step), .dir(dir), .busy(busy), .done(done), .error(error), .track_reg(track_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    pulses;
    int    dir;
    int    track;
    int    err;
    int    per;
    int    dticks;
    int    maxlat;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_push = 0;
  int n_done = 0;

  bit in_cmd = 0;
  int m_pulses, m_ticks, m_wcnt, m_wmin, m_wmax, m_pmin, m_pmax, m_lat;
  int m_dir_first, m_dir_bad, m_setup_bad;
  logic prev_step = 1'b0, prev_dir = 1'b0, prev_done = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input string tag, input int pulses, input int d, input int trk,
                            input int err, input int per, input int dticks, input int maxlat);
    exp_t e;
    e.tag = tag; e.pulses = pulses; e.dir = d; e.track = trk; e.err = err;
    e.per = per; e.dticks = dticks; e.maxlat = maxlat;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic finish_txn();
    exp_t e;
    n_done++;
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    $display("txn %s: pulses=%0d dir=%0d track_reg=%0d error=%0d width=%0d..%0d period=%0d..%0d done_ticks=%0d lat=%0d",
             e.tag, m_pulses, m_dir_first, track_reg, error, m_wmin, m_wmax, m_pmin, m_pmax, m_ticks, m_lat);
    check({e.tag, ".pulses"}, m_pulses, e.pulses);
    check({e.tag, ".track"}, int'(track_reg), e.track);
    check({e.tag, ".error"}, int'(error), e.err);
    check({e.tag, ".busy"}, int'(busy), 0);
    check({e.tag, ".lat_ok"}, int'(m_lat <= e.maxlat), 1);
    if (m_pulses > 0) begin
      check({e.tag, ".width_min"}, m_wmin, int'(P_T));
      check({e.tag, ".width_max"}, m_wmax, int'(P_T));
      check({e.tag, ".dir"}, m_dir_first, e.dir);
      check({e.tag, ".dir_stable"}, m_dir_bad, 0);
      check({e.tag, ".dir_setup"}, m_setup_bad, 0);
      check({e.tag, ".done_ticks"}, m_ticks, e.dticks);
    end
    if (m_pulses > 1) begin
      check({e.tag, ".period_min"}, m_pmin, e.per);
      check({e.tag, ".period_max"}, m_pmax, e.per);
    end
  endtask

  // Tick enable: one cycle in four, changed just after the rising edge
  initial begin
    clk_3mhz_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      en_div = (en_div + 1) % 4;
      clk_3mhz_en = (en_div == 0);
    end
  end

  // Drive mechanics: head moves on the falling edge of step when enabled
  initial begin
    drive_pos = 6'd7;
    forever begin
      @(negedge step);
      if (drive_moves) begin
        if (dir) begin
          if (drive_pos != 6'd63) drive_pos = drive_pos + 6'd1;
        end else if (drive_pos != 6'd0) begin
          drive_pos = drive_pos - 6'd1;
        end
      end
    end
  end

  // Monitor: measures pulses in ticks and retires transactions on done
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_cmd = 0;
        sb.delete();
        prev_step = step;
        prev_dir  = dir;
        prev_done = done;
      end else begin
        if (prev_done) check("done_one_clk", int'(done), 0);
        if (busy && !in_cmd) begin
          in_cmd = 1; m_pulses = 0; m_ticks = 0; m_wcnt = 0;
          m_wmin = 1 << 30; m_wmax = 0; m_pmin = 1 << 30; m_pmax = 0;
          m_lat = 0; m_dir_first = 0; m_dir_bad = 0; m_setup_bad = 0;
        end
        if (in_cmd) begin
          if (step && !prev_step) begin
            if (m_pulses > 0) begin
              if (m_ticks < m_pmin) m_pmin = m_ticks;
              if (m_ticks > m_pmax) m_pmax = m_ticks;
            end
            if (dir != prev_dir) m_setup_bad = 1;
            if (m_pulses == 0) m_dir_first = int'(dir);
            else if (int'(dir) != m_dir_first) m_dir_bad = 1;
            m_pulses++;
            m_ticks = 0;
            m_wcnt = 0;
          end else if (step && dir != prev_dir) begin
            m_dir_bad = 1;
          end
          if (!step && prev_step) begin
            if (m_wcnt < m_wmin) m_wmin = m_wcnt;
            if (m_wcnt > m_wmax) m_wmax = m_wcnt;
          end
          if (done) begin
            finish_txn();
            in_cmd = 0;
          end else begin
            m_lat++;
            m_ticks += int'(clk_3mhz_en);
            if (step) m_wcnt += int'(clk_3mhz_en);
          end
        end else if (done) begin
          check("done_without_cmd", 1, 0);
        end
        prev_step = step;
        prev_dir  = dir;
        prev_done = done;
      end
    end
  end

  task automatic issue(input logic rst, input logic [1:0] rt, input logic [5:0] tg, input int hold);
    @(posedge clk);
    #1;
    cmd_restore  = rst;
    cmd_rate     = rt;
    target_track = tg;
    cmd_strobe   = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    cmd_strobe = 1'b0;
  endtask

  task automatic wait_all_done(input int max_clks);
    int i;
    for (i = 0; i < max_clks; i++) begin
      @(posedge clk);
      if (n_done >= n_push) break;
    end
    if (i == max_clks) check("timeout_done", n_done, n_push);
  endtask

  task automatic wait_pulses(input int n, input int max_clks);
    int i;
    for (i = 0; i < max_clks; i++) begin
      @(posedge clk);
      if (m_pulses >= n) break;
    end
    if (i == max_clks) check("timeout_pulses", m_pulses, n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".step"}, int'(step), 0);
    check({tag, ".dir"}, int'(dir), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".error"}, int'(error), 0);
    check({tag, ".track"}, int'(track_reg), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_strobe = 1'b0; cmd_restore = 1'b0; cmd_rate = 2'd0; target_track = 6'd0;
    drive_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_hold");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_idle");

    expect_txn("seek0to3", 3, 1, 3, 0, R0, R0 + S, BIG);
    issue(1'b0, 2'd0, 6'd3, 1);
    wait_all_done(4000);

    expect_txn("seek3to1", 2, 0, 1, 0, R2, R2 + S, BIG);
    issue(1'b0, 2'd2, 6'd1, 1);
    wait_all_done(4000);

    // A restore strobe arriving mid-seek must not disturb the seek
    expect_txn("seek1to5", 4, 1, 5, 0, R3, R3 + S, BIG);
    issue(1'b0, 2'd3, 6'd5, 1);
    wait_pulses(1, 2000);
    issue(1'b1, 2'd0, 6'd0, 1);
    wait_all_done(4000);

    expect_txn("seek5to5", 0, 0, 5, 0, 0, 0, 2);
    issue(1'b0, 2'd1, 6'd5, 1);
    wait_all_done(100);

    drive_hold9 = 1'b1;
    expect_txn("restore_stuck", int'(LIM), 0, 5, 1, R0, R0, BIG);
    issue(1'b1, 2'd0, 6'd0, 1);
    wait_all_done(4000);
    drive_hold9 = 1'b0;

    drive_moves = 1'b1;
    expect_txn("restore7", 7, 0, 0, 0, R1, R1 + S, BIG);
    issue(1'b1, 2'd1, 6'd0, 1);
    wait_all_done(4000);
    drive_moves = 1'b0;

    // Strobe held over the CHECK and DONE cycles: only the first is taken
    drive_ready = 1'b0;
    expect_txn("not_ready", 0, 0, 0, 1, 0, 0, 2);
    issue(1'b0, 2'd0, 6'd9, 3);
    wait_all_done(100);
    repeat (5) @(posedge clk);
    #1;
    check("not_ready.idle_after", int'(busy), 0);
    check("not_ready.err_held", int'(error), 1);
    drive_ready = 1'b1;

    expect_txn("ready_drop", 2, 1, 2, 1, R1, R1, BIG);
    issue(1'b0, 2'd1, 6'd4, 1);
    wait_pulses(1, 2000);
    #1;
    check("ready_drop.err_cleared", int'(error), 0);
    wait_pulses(2, 2000);
    #1;
    drive_ready = 1'b0;
    wait_all_done(4000);
    drive_ready = 1'b1;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst2");
    reset_n = 1'b1;
    issue(1'b0, 2'd0, 6'd10, 1);
    wait_pulses(3, 4000);
    #2;
    check("mid_pulse.step_high", int'(step), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("rst_async");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    expect_txn("seek0to1", 1, 1, 1, 0, R0, R0 + S, BIG);
    issue(1'b0, 2'd0, 6'd1, 1);
    wait_all_done(4000);

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
